// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RISC-V funct3 size codes, access-size decoding and funct3 legality.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_REQ_HI  = 3'd4,
    ST_WAIT_HI = 3'd5
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] n;
    case (funct3[1:0])
      2'd0:    n = 4'd1;
      2'd1:    n = 4'd2;
      2'd2:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // D and WU only exist on a 64-bit datapath.
  function automatic logic f3_legal(input logic is_load, input logic is_64,
                                    input logic [2:0] funct3);
    logic ok;
    if (is_load) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        F3_D, F3_WU:                    ok = is_64;
        default:                        ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        F3_D:             ok = is_64;
        default:          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable / data shift over a two-word
// window, and load extraction with sign/zero extension from a two-word window.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFS_W = $clog2(NB)
) (
  input  logic [2:0]        funct3_i,
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [2*XLEN-1:0] rwin_i,
  output logic [2*NB-1:0]   be_o,
  output logic [2*XLEN-1:0] wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [3:0]        nbytes_s;
  logic [NB-1:0]     bm_s;
  logic [XLEN-1:0]   msk_s;
  logic [2*XLEN-1:0] win_s;
  logic              sgn_s;

  assign nbytes_s = size_bytes(funct3_i);
  assign be_o     = {{NB{1'b0}}, bm_s} << ofs_i;
  assign wdata_o  = {{XLEN{1'b0}}, wdata_i} << {ofs_i, 3'b000};
  assign win_s    = rwin_i >> {ofs_i, 3'b000};

  // Byte and bit masks covering the access size.
  always_comb begin
    bm_s  = '0;
    msk_s = '0;
    for (int i = 0; i < NB; i++) begin
      bm_s[i]         = (4'(i) < nbytes_s);
      msk_s[8*i +: 8] = {8{4'(i) < nbytes_s}};
    end
  end

  // Sign bit of the extracted field; funct3[2] marks the unsigned variants.
  always_comb begin
    case (funct3_i[1:0])
      2'd0:    sgn_s = win_s[7];
      2'd1:    sgn_s = win_s[15];
      2'd2:    sgn_s = win_s[31];
      default: sgn_s = win_s[XLEN-1];
    endcase
    if (sgn_s && !funct3_i[2]) begin
      rdata_o = (win_s[XLEN-1:0] & msk_s) | ~msk_s;
    end else begin
      rdata_o = win_s[XLEN-1:0] & msk_s;
    end
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit between execute stage and word-addressed memory port.
// Optional LSU_MISALIGNED_SPLIT_EN makes misaligned accesses legal (split on word crossing).
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  ADDR_W = 32,
  localparam int NB     = XLEN / 8,
  localparam int OFS_W  = $clog2(NB)
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NB-1:0]     mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  localparam logic IS64 = (XLEN == 64);

  lsu_state_t        state_q, state_d;
  logic              load_q, load_d, cross_q, cross_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, lo_word_q, lo_word_d;
  logic              req_ready_q, req_ready_d, busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              mem_req_valid_q, mem_req_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, hi_addr_s;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic [3:0]        sz_s;
  logic [4:0]        end_s;
  logic              illegal_s, misal_s, err_s, cross_s;
  logic [2:0]        al_f3_s;
  logic [OFS_W-1:0]  al_ofs_s;
  logic [XLEN-1:0]   al_wdata_s, ext_s;
  logic [2*XLEN-1:0] rwin_s, wd2_s;
  logic [2*NB-1:0]   be2_s;

  assign sz_s      = size_bytes(req_funct3);
  assign illegal_s = !f3_legal(req_load, IS64, req_funct3);
  assign misal_s   = |(req_addr[2:0] & (sz_s[2:0] - 3'd1));
  assign end_s     = 5'(req_addr[OFS_W-1:0]) + 5'(sz_s);

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign err_s   = illegal_s;
  assign cross_s = (end_s > 5'(NB));
`else
  assign err_s   = illegal_s | misal_s;
  assign cross_s = 1'b0;
`endif

  // In IDLE the lanes are computed from the incoming request so the first
  // memory request can be registered on the accept edge.
  assign al_f3_s    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
  assign al_ofs_s   = (state_q == ST_IDLE) ? req_addr[OFS_W-1:0] : addr_q[OFS_W-1:0];
  assign al_wdata_s = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign rwin_s     = (state_q == ST_WAIT_HI) ? {mem_rdata, lo_word_q}
                                              : {{XLEN{1'b0}}, mem_rdata};
  assign hi_addr_s  = {addr_q[ADDR_W-1:OFS_W] + {{(ADDR_W-OFS_W-1){1'b0}}, 1'b1},
                       {OFS_W{1'b0}}};

  lsu_align #(.XLEN(XLEN), .NB(NB), .OFS_W(OFS_W)) u_align (
    .funct3_i (al_f3_s),
    .ofs_i    (al_ofs_s),
    .wdata_i  (al_wdata_s),
    .rwin_i   (rwin_s),
    .be_o     (be2_s),
    .wdata_o  (wd2_s),
    .rdata_o  (ext_s)
  );

  // Next-state and registered-output logic for the request FSM.
  always_comb begin
    state_d         = state_q;
    load_d          = load_q;
    cross_d         = cross_q;
    f3_d            = f3_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    lo_word_d       = lo_word_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;
    resp_valid_d    = 1'b0;
    resp_err_d      = 1'b0;
    resp_rdata_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load_d  = req_load;
          cross_d = cross_s;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (err_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d         = ST_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = !req_load;
            mem_addr_d      = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            mem_be_d        = be2_s[NB-1:0];
            mem_wdata_d     = wd2_s[XLEN-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ, ST_REQ_HI: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          mem_we_d        = 1'b0;
          mem_addr_d      = '0;
          mem_be_d        = '0;
          mem_wdata_d     = '0;
          if (load_q) begin
            state_d = (state_q == ST_REQ) ? ST_WAIT : ST_WAIT_HI;
          end else if (cross_q && (state_q == ST_REQ)) begin
            state_d         = ST_REQ_HI;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b1;
            mem_addr_d      = hi_addr_s;
            mem_be_d        = be2_s[2*NB-1:NB];
            mem_wdata_d     = wd2_s[2*XLEN-1:XLEN];
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT, ST_WAIT_HI: begin
        if (mem_rvalid) begin
          if (cross_q && (state_q == ST_WAIT)) begin
            lo_word_d       = mem_rdata;
            state_d         = ST_REQ_HI;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b0;
            mem_addr_d      = hi_addr_s;
            mem_be_d        = be2_s[2*NB-1:NB];
            mem_wdata_d     = wd2_s[2*XLEN-1:XLEN];
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = ext_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; resetn abandons any outstanding access.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      load_q          <= 1'b0;
      cross_q         <= 1'b0;
      f3_q            <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      lo_word_q       <= '0;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_be_q        <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      load_q          <= load_d;
      cross_q         <= cross_d;
      f3_q            <= f3_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      lo_word_q       <= lo_word_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed scoreboard bench for lsu_unit: one XLEN=32 and one XLEN=64 instance
// share stimulus; sel64 picks which one is driven and observed.
module tb_lsu_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        resetn, sel64, req_valid, req_load, mem_req_ready, mem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_we, a_busy;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_we, b_busy;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_be;

  lsu_unit #(.XLEN(32)) u_dut32 (
    .CLK(CLK), .resetn(resetn), .req_valid(req_valid & ~sel64), .req_ready(a_req_ready),
    .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(a_resp_valid), .resp_err(a_resp_err),
    .resp_rdata(a_resp_rdata), .mem_req_valid(a_mem_req_valid),
    .mem_req_ready(mem_req_ready & ~sel64), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rvalid(mem_rvalid & ~sel64),
    .mem_rdata(mem_rdata[31:0]), .busy(a_busy)
  );

  lsu_unit #(.XLEN(64)) u_dut64 (
    .CLK(CLK), .resetn(resetn), .req_valid(req_valid & sel64), .req_ready(b_req_ready),
    .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_err(b_resp_err),
    .resp_rdata(b_resp_rdata), .mem_req_valid(b_mem_req_valid),
    .mem_req_ready(mem_req_ready & sel64), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rvalid(mem_rvalid & sel64),
    .mem_rdata(mem_rdata), .busy(b_busy)
  );

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we, o_busy;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_be;
  assign o_req_ready     = sel64 ? b_req_ready     : a_req_ready;
  assign o_resp_valid    = sel64 ? b_resp_valid    : a_resp_valid;
  assign o_resp_err      = sel64 ? b_resp_err      : a_resp_err;
  assign o_mem_req_valid = sel64 ? b_mem_req_valid : a_mem_req_valid;
  assign o_mem_we        = sel64 ? b_mem_we        : a_mem_we;
  assign o_busy          = sel64 ? b_busy          : a_busy;
  assign o_resp_rdata    = sel64 ? b_resp_rdata    : {32'd0, a_resp_rdata};
  assign o_mem_wdata     = sel64 ? b_mem_wdata     : {32'd0, a_mem_wdata};
  assign o_mem_addr      = sel64 ? b_mem_addr      : a_mem_addr;
  assign o_mem_be        = sel64 ? b_mem_be        : {4'd0, a_mem_be};

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_m[logic [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_delay = 0;
  int          e_n;
  logic [31:0] e_addr[2];
  logic [7:0]  e_be[2];
  logic [63:0] e_wd[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    else return 64'd0;
  endfunction

  task automatic exp_req(input int n, input logic [31:0] a0, input logic [7:0] b0,
                         input logic [63:0] w0, input logic [31:0] a1,
                         input logic [7:0] b1, input logic [63:0] w1);
    e_n = n; e_addr[0] = a0; e_be[0] = b0; e_wd[0] = w0;
    e_addr[1] = a1; e_be[1] = b1; e_wd[1] = w1;
  endtask

  // One transaction: drive, act as memory, pop and compare on resp_valid.
  task automatic run(input string tag, input logic ld, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wd, input logic x_err,
                     input logic [63:0] x_rd, input int x_lat);
    exp_t        e, got;
    int          cyc, nreq, stall;
    logic        pend, done;
    logic [31:0] paddr;
    e.err = x_err; e.rdata = x_rd; e.lat = x_lat;
    sb.push_back(e);
    @(negedge CLK);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk({tag, ".req_ready"}, {63'd0, o_req_ready}, 64'd1);
    @(posedge CLK);
    cyc = 0; nreq = 0; stall = 0; pend = 1'b0; done = 1'b0; paddr = 32'd0;
    while (!done && cyc < 30) begin
      @(negedge CLK);
      cyc++;
      req_valid = 1'b0; mem_rvalid = 1'b0; mem_req_ready = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = mem_rd(paddr); pend = 1'b0;
      end
      if (o_resp_valid) begin
        got = sb.pop_front();
        chk({tag, ".err"}, {63'd0, o_resp_err}, {63'd0, got.err});
        chk({tag, ".rdata"}, o_resp_rdata, got.rdata);
        chk({tag, ".latency"}, 64'(cyc), 64'(got.lat));
        done = 1'b1;
      end else if (o_mem_req_valid) begin
        if (nreq < 2) begin
          chk({tag, ".mem_addr"}, {32'd0, o_mem_addr}, {32'd0, e_addr[nreq]});
          chk({tag, ".mem_be"}, {56'd0, o_mem_be}, {56'd0, e_be[nreq]});
          chk({tag, ".mem_we"}, {63'd0, o_mem_we}, {63'd0, ~ld});
          if (!ld) chk({tag, ".mem_wdata"}, o_mem_wdata, e_wd[nreq]);
        end
        if (stall >= rdy_delay) begin
          mem_req_ready = 1'b1; paddr = o_mem_addr; pend = ld; nreq++; stall = 0;
        end else begin
          stall++;
        end
      end
    end
    if (!done) chk({tag, ".timeout"}, 64'd0, 64'd1);
    chk({tag, ".nreq"}, 64'(nreq), 64'(e_n));
  endtask

  initial begin
    resetn = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 64'd0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 64'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    resetn = 1'b1;
    chk("rst32.req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("rst32.mem_req_valid", {63'd0, o_mem_req_valid}, 64'd0);
    chk("rst32.busy", {63'd0, o_busy}, 64'd0);
    sel64 = 1'b1;
    #1;
    chk("rst64.req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("rst64.resp_valid", {63'd0, o_resp_valid}, 64'd0);
    sel64 = 1'b0;

    // ---- XLEN = 32 ----
    exp_req(1, 32'h100, 8'h0F, 64'hDEADBEEF, 32'h0, 8'h0, 64'h0);
    run("sw", 1'b0, 3'b010, 32'h100, 64'hDEADBEEF, 1'b0, 64'h0, 2);
    mem_m[32'h200] = 64'h80FF_1234;
    exp_req(1, 32'h200, 8'h08, 64'h0, 32'h0, 8'h0, 64'h0);
    run("lb", 1'b1, 3'b000, 32'h203, 64'h0, 1'b0, 64'hFFFF_FF80, 3);
    run("lbu", 1'b1, 3'b100, 32'h203, 64'h0, 1'b0, 64'h0000_0080, 3);
    exp_req(1, 32'h100, 8'h02, 64'h0000_A500, 32'h0, 8'h0, 64'h0);
    run("sb", 1'b0, 3'b000, 32'h101, 64'h0000_00A5, 1'b0, 64'h0, 2);
    exp_req(1, 32'h104, 8'h0C, 64'h1234_0000, 32'h0, 8'h0, 64'h0);
    run("sh", 1'b0, 3'b001, 32'h106, 64'h0000_1234, 1'b0, 64'h0, 2);
    mem_m[32'h200] = 64'h8001_0000;
    rdy_delay = 3;
    exp_req(1, 32'h200, 8'h0C, 64'h0, 32'h0, 8'h0, 64'h0);
    run("lh_stall", 1'b1, 3'b001, 32'h202, 64'h0, 1'b0, 64'hFFFF_8001, 6);
    rdy_delay = 0;
    exp_req(0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0);
    run("ld_on32", 1'b1, 3'b011, 32'h100, 64'h0, 1'b1, 64'h0, 1);
    run("sbu_illegal", 1'b0, 3'b100, 32'h100, 64'h0, 1'b1, 64'h0, 1);
    run("f3_111", 1'b1, 3'b111, 32'h100, 64'h0, 1'b1, 64'h0, 1);
    mem_m[32'h100] = 64'h4433_2211;
    mem_m[32'h104] = 64'h8877_6655;
    mem_m[32'h200] = 64'h80FF_1234;
`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_req(2, 32'h100, 8'h0C, 64'h0, 32'h104, 8'h03, 64'h0);
    run("lw_split", 1'b1, 3'b010, 32'h102, 64'h0, 1'b0, 64'h6655_4433, 5);
    exp_req(2, 32'h100, 8'h0C, 64'hCCDD_0000, 32'h104, 8'h03, 64'h0000_AABB);
    run("sw_split", 1'b0, 3'b010, 32'h102, 64'hAABB_CCDD, 1'b0, 64'h0, 3);
    exp_req(1, 32'h200, 8'h06, 64'h0, 32'h0, 8'h0, 64'h0);
    run("lh_inword", 1'b1, 3'b001, 32'h201, 64'h0, 1'b0, 64'hFFFF_FF12, 3);
`else
    run("lw_misal", 1'b1, 3'b010, 32'h102, 64'h0, 1'b1, 64'h0, 1);
    run("sw_misal", 1'b0, 3'b010, 32'h102, 64'hAABB_CCDD, 1'b1, 64'h0, 1);
    run("lh_misal", 1'b1, 3'b001, 32'h201, 64'h0, 1'b1, 64'h0, 1);
`endif

    // ---- reset while waiting for read data ----
    @(negedge CLK);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rstw.mem_req_valid", {63'd0, o_mem_req_valid}, 64'd1);
    mem_req_ready = 1'b1;
    @(negedge CLK);
    mem_req_ready = 1'b0;
    chk("rstw.busy_wait", {63'd0, o_busy}, 64'd1);
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    chk("rstw.req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("rstw.busy", {63'd0, o_busy}, 64'd0);
    chk("rstw.resp_valid", {63'd0, o_resp_valid}, 64'd0);
    chk("rstw.resp_err", {63'd0, o_resp_err}, 64'd0);
    chk("rstw.resp_rdata", o_resp_rdata, 64'd0);
    chk("rstw.mem_req_valid0", {63'd0, o_mem_req_valid}, 64'd0);
    chk("rstw.mem_we", {63'd0, o_mem_we}, 64'd0);
    chk("rstw.mem_addr", {32'd0, o_mem_addr}, 64'd0);
    chk("rstw.mem_be", {56'd0, o_mem_be}, 64'd0);
    chk("rstw.mem_wdata", o_mem_wdata, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344;
    @(negedge CLK);
    mem_rvalid = 1'b0;
    chk("rstw.late_rvalid0", {63'd0, o_resp_valid}, 64'd0);
    @(negedge CLK);
    chk("rstw.late_rvalid1", {63'd0, o_resp_valid}, 64'd0);

    // ---- XLEN = 64 ----
    sel64 = 1'b1;
    mem_m[32'h0] = 64'hF000_0000_0000_0000;
    mem_m[32'h8] = 64'h0123_4567_89AB_CDEF;
    exp_req(1, 32'h0, 8'hF0, 64'h0, 32'h0, 8'h0, 64'h0);
    run("lwu64", 1'b1, 3'b110, 32'h4, 64'h0, 1'b0, 64'h0000_0000_F000_0000, 3);
    run("lw64", 1'b1, 3'b010, 32'h4, 64'h0, 1'b0, 64'hFFFF_FFFF_F000_0000, 3);
    exp_req(1, 32'h8, 8'hFF, 64'h0, 32'h0, 8'h0, 64'h0);
    run("ld64", 1'b1, 3'b011, 32'h8, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 3);
    exp_req(1, 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 32'h0, 8'h0, 64'h0);
    run("sd64", 1'b0, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 2);
    exp_req(1, 32'h10, 8'hF0, 64'h89AB_CDEF_0000_0000, 32'h0, 8'h0, 64'h0);
    run("sw64", 1'b0, 3'b010, 32'h14, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 2);
    exp_req(0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0);
    run("f3_111_64", 1'b1, 3'b111, 32'h8, 64'h0, 1'b1, 64'h0, 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_req(2, 32'h0, 8'hF0, 64'h0, 32'h8, 8'h0F, 64'h0);
    run("ld64_split", 1'b1, 3'b011, 32'h4, 64'h0, 1'b0, 64'h89AB_CDEF_F000_0000, 5);
`else
    run("ld64_misal", 1'b1, 3'b011, 32'h4, 64'h0, 1'b1, 64'h0, 1);
`endif
    sel64 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Parametrised load/store unit that takes the core's byte-level memory traffic out of the datapath.
- Accepts one load/store request from the core at a time, validates alignment and funct3, and drives a word-addressed memory port with byte enables and a valid/ready handshake.
- Returns load data aligned and sign/zero-extended.
- Sits between the core execute stage and the memory/bus interface. Generalised to XLEN 32/64, including LD/SD/LWU when XLEN=64.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- NB, XLEN/8, bytes per memory word (derived, not overridable).
- OFS_W, $clog2(NB), byte-offset width (derived).

Ports:
- CLK  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_load  in  1  1 = load, 0 = store
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (low OFS_W bits 0)
- mem_be  out  NB  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word
- busy  out  1  state != IDLE

Behaviour:
- One clock CLK; synchronous active-low reset resetn.
- Reset (and reset mid-transaction): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_req_valid=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0. An outstanding memory read is abandoned; a late mem_rvalid in IDLE is ignored.
- States: IDLE, REQ, WAIT, RESP (+REQ_HI, WAIT_HI with option).
- IDLE
  - req_ready=1.
  - On req_valid: capture all request fields.
  - If illegal or misaligned → RESP with err=1.
  - Otherwise → REQ.
- Legal sizes (funct3):
  - Loads: 000 B, 001 H, 010 W, 100 BU, 101 HU; for XLEN=64 also 011 D and 110 WU.
  - Stores: 000, 001, 010; for XLEN=64 also 011.
  - Anything else is illegal.
- Misaligned: addr mod size != 0.
- REQ
  - mem_req_valid=1, mem_addr=addr & ~(NB-1), mem_we=!load.
  - mem_be = ((1<<size)-1) << ofs; mem_wdata = wdata << (8*ofs).
  - All held stable until mem_req_ready.
  - On handshake: store → RESP; load → WAIT.
- WAIT: on mem_rvalid, extract bytes at ofs and sign/zero-extend to XLEN into resp_rdata, then → RESP.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. There is no response backpressure.
- Latency from the accept cycle to resp_valid, with mem_req_ready=1 and mem_rvalid one cycle after the request handshake:
  - store: 2 cycles
  - load: 3 cycles
  - error: 1 cycle
- mem_rvalid outside WAIT/WAIT_HI is ignored.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Undefined: every misaligned access returns resp_err=1 with no memory traffic.
- Defined: misaligned accesses are legal.
  - An access inside one word issues a single request with shifted mem_be.
  - A word-crossing access issues two requests:
    - REQ/WAIT for the low word, with bytes ofs..NB-1.
    - REQ_HI/WAIT_HI for address+NB, with the remaining bytes at lanes 0..
  - Load data is merged into a 2*XLEN window before extension.
  - A store issues its high request after the low handshake.
  - One resp_valid is returned after the final part.
  - Illegal funct3 still returns an error.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum lsu_state_t.
  - funct3 localparams F3_B/H/W/D/BU/HU/WU.
  - function size_bytes(funct3).
- Sub-module lsu_align (combinational): store lane shift + byte-enable generation, and load extract/extend. Instantiated once, reused for both split halves.

Test Plan:
- XLEN=32, SW addr 0x100 data 0xDEADBEEF, ready=1 → mem_addr 0x100, be 1111, wdata 0xDEADBEEF; resp_valid 2 cycles after accept, err=0.
- LB addr 0x203, mem_rdata 0x80FF_1234 → be 1000, resp_rdata 0xFFFFFF80. LBU same → 0x00000080.
- LH addr 0x202, rdata 0x8001_0000 → resp_rdata 0xFFFF8001. mem_req_ready held 0 for 3 cycles → request fields stable, resp delayed 3 cycles.
- LW addr 0x102, macro off → resp_err=1 one cycle after accept, mem_req_valid never asserted. Funct3 011 at XLEN=32 → err.
- Macro on, LW addr 0x102, words 0x100=0x4433_2211 and 0x104=0x8877_6655 → two requests (be 1100 then 0011), resp_rdata 0x66554433.
- resetn=0 during WAIT → next cycle IDLE, all outputs 0; a subsequent mem_rvalid produces no resp_valid. XLEN=64 LWU addr 0x4, rdata 0xF000_0000_0000_0000 → resp 0x00000000F0000000.
